// File: rtl/instr_fetch_stage.sv
// ============================================================================
// instr_fetch_stage
//
// Fetch stage that sits directly upstream of the control unit. It holds the
// program counter and keeps at most one instruction-memory request in flight.
// It latches each returned word and presents it to decode with a valid/ready
// handshake, along with the 6-bit opcode field the control unit consumes.
// A redirect from execute (taken branch or jump) reloads the PC. Any fetch
// that is already in flight on the old path is discarded when it returns.
//
// Ports
//   clk             single clock; all state changes on the rising edge
//   rst             synchronous, active-high reset
//   imem_req_valid  fetch request valid (forced low while rst is high)
//   imem_req_ready  memory accepts the request this cycle
//   imem_req_addr   fetch address (the current pc)
//   imem_rsp_valid  response word valid (one per accepted request)
//   imem_rsp_data   returned instruction word
//   redirect_valid  branch/jump taken; load redirect_pc
//   redirect_pc     redirect target; the two low bits are ignored
//   out_valid       instruction valid towards decode
//   out_ready       decode accepts the instruction
//   out_instr       registered instruction word
//   out_opcode      out_instr[31:26], feeds the control unit
//   out_pc          pc of out_instr
//   fetch_count     number of instructions handed to decode (wraps)
// ============================================================================
module instr_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [5:0]         out_opcode,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [CNT_W-1:0]   fetch_count
);

    // FETCH: request pending. WAIT: request accepted, awaiting the word.
    // FULL: word captured, waiting for decode to take it.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_reg,       state_next;
    logic [ADDR_W-1:0]   pc_reg,          pc_next;
    logic                drop_reg,        drop_next;
    logic                out_valid_reg,   out_valid_next;
    logic [INSTR_W-1:0]  out_instr_reg,   out_instr_next;
    logic [ADDR_W-1:0]   out_pc_reg,      out_pc_next;
    logic [CNT_W-1:0]    fetch_count_reg, fetch_count_next;

    // Redirect targets are word aligned. Masking the low bits keeps every
    // input bit in use and gives the same result as concatenating zeros.
    logic [ADDR_W-1:0]   redirect_target;
    logic [ADDR_W-1:0]   pc_plus4;

    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign pc_plus4        = pc_reg + ADDR_W'(4);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_FETCH;
            pc_reg          <= RESET_PC;
            drop_reg        <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_instr_reg   <= '0;
            out_pc_reg      <= '0;
            fetch_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            drop_reg        <= drop_next;
            out_valid_reg   <= out_valid_next;
            out_instr_reg   <= out_instr_next;
            out_pc_reg      <= out_pc_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A redirect takes priority in every state.
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        drop_next        = drop_reg;
        out_valid_next   = out_valid_reg;
        out_instr_next   = out_instr_reg;
        out_pc_next      = out_pc_reg;
        fetch_count_next = fetch_count_reg;

        case (state_reg)
            ST_FETCH: begin
                if (redirect_valid) begin
                    // The request is suppressed this cycle, so nothing was
                    // accepted. Retry from the new pc.
                    pc_next = redirect_target;
                end else if (imem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (imem_rsp_valid) begin
                        // The wrong-path word arrives together with the
                        // redirect. Discard it and fetch the target.
                        drop_next  = 1'b0;
                        state_next = ST_FETCH;
                    end else begin
                        // Still in flight. Mark it so it is thrown away when
                        // it returns. If drop was already set, it stays set.
                        drop_next = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_reg) begin
                        drop_next  = 1'b0;
                        state_next = ST_FETCH;
                    end else begin
                        out_instr_next = imem_rsp_data;
                        out_pc_next    = pc_reg;
                        out_valid_next = 1'b1;
                        pc_next        = pc_plus4;
                        state_next     = ST_FULL;
                    end
                end
            end

            ST_FULL: begin
                if (redirect_valid) begin
                    // Without out_ready the held instruction is squashed.
                    // With out_ready the handshake still completes.
                    pc_next        = redirect_target;
                    out_valid_next = 1'b0;
                    state_next     = ST_FETCH;
                    if (out_ready) begin
                        fetch_count_next = fetch_count_reg + CNT_W'(1);
                    end
                end else if (out_ready) begin
                    out_valid_next   = 1'b0;
                    fetch_count_next = fetch_count_reg + CNT_W'(1);
                    state_next       = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_valid = 1'b0;
        if (!rst && (state_reg == ST_FETCH) && !redirect_valid) begin
            imem_req_valid = 1'b1;
        end
    end

    assign imem_req_addr = pc_reg;
    assign out_valid     = out_valid_reg;
    assign out_instr     = out_instr_reg;
    assign out_pc        = out_pc_reg;
    assign fetch_count   = fetch_count_reg;

    // The opcode is a plain slice of the registered word, so it reads zero
    // after reset along with out_instr.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_opcode
            assign out_opcode[gi] = out_instr_reg[26 + gi];
        end
    endgenerate

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- main instance (32-bit address) ----------------
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_instr, out_pc, fetch_count;
    logic [5:0]  out_opcode;

    instr_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_opcode(out_opcode), .out_pc(out_pc),
        .fetch_count(fetch_count)
    );

    // ---------------- small instance (8-bit address, pc wrap) ----------------
    logic        rst8 = 1'b1;
    logic        req_valid8, req_ready8 = 1'b0;
    logic [7:0]  req_addr8;
    logic        rsp_valid8 = 1'b0;
    logic [31:0] rsp_data8 = '0;
    logic        redir8 = 1'b0;
    logic [7:0]  redir_pc8 = '0;
    logic        out_valid8, out_ready8 = 1'b0;
    logic [31:0] out_instr8;
    logic [7:0]  out_pc8, fetch_count8;
    logic [5:0]  out_opcode8;

    instr_fetch_stage #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hFC), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst8),
        .imem_req_valid(req_valid8), .imem_req_ready(req_ready8),
        .imem_req_addr(req_addr8), .imem_rsp_valid(rsp_valid8),
        .imem_rsp_data(rsp_data8), .redirect_valid(redir8),
        .redirect_pc(redir_pc8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_instr(out_instr8), .out_opcode(out_opcode8), .out_pc(out_pc8),
        .fetch_count(fetch_count8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus together with the outputs expected in that cycle
    // (before the clock edge).
    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rr;
        logic        rsp;
        logic [31:0] rdata;
        logic        ordy;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_ov;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t v(logic redir, logic [31:0] rpc, logic rr, logic rsp,
                               logic [31:0] rdata, logic ordy, logic e_rv, logic [31:0] e_ra,
                               logic e_ov, logic [31:0] e_instr, logic [31:0] e_pc,
                               logic [31:0] e_cnt);
        vec_t r;
        r.redir = redir; r.rpc = rpc; r.rr = rr; r.rsp = rsp; r.rdata = rdata;
        r.ordy = ordy; r.e_rv = e_rv; r.e_ra = e_ra; r.e_ov = e_ov;
        r.e_instr = e_instr; r.e_pc = e_pc; r.e_cnt = e_cnt;
        return r;
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    task automatic reset_main();
        @(negedge clk);
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_opcode", out_opcode, 6'h0);
        chk("rst_count", fetch_count, 32'h0);
        rst = 1'b0;
    endtask

    localparam logic [31:0] I0 = 32'h0C00_0000;
    localparam logic [31:0] I1 = 32'h0400_0000;
    localparam logic [31:0] I2 = 32'h0800_0000;

    vec_t vecs[25];

    // Transaction-level reference model state
    logic [31:0] m_pc, m_instr, m_outpc, m_cnt, mem_data, tmp;
    logic        m_hold, m_inflight, m_stale, exp_req, accepted;
    int          mem_timer;

    initial begin
        // ---------------- directed table ----------------
        vecs[0]  = v(0, 0,      1, 0, 0,            0, 1, 32'h0,   0, 0,  0,       0);
        vecs[1]  = v(0, 0,      1, 1, I0,           0, 0, 0,       0, 0,  0,       0);
        for (int i = 2; i <= 6; i++)
            vecs[i] = v(0, 0,   1, 0, 0,            0, 0, 0,       1, I0, 0,       0);
        vecs[7]  = v(0, 0,      1, 0, 0,            1, 0, 0,       1, I0, 0,       0);
        vecs[8]  = v(0, 0,      1, 0, 0,            0, 1, 32'h4,   0, I0, 0,       1);
        vecs[9]  = v(1, 32'h103,1, 0, 0,            0, 0, 0,       0, I0, 0,       1);
        vecs[10] = v(0, 0,      1, 0, 0,            0, 0, 0,       0, I0, 0,       1);
        vecs[11] = v(0, 0,      1, 0, 0,            0, 0, 0,       0, I0, 0,       1);
        vecs[12] = v(0, 0,      1, 1, 32'hDEADBEEF, 0, 0, 0,       0, I0, 0,       1);
        vecs[13] = v(0, 0,      1, 0, 0,            0, 1, 32'h100, 0, I0, 0,       1);
        vecs[14] = v(1, 32'h200,1, 1, 32'hCAFEF00D, 0, 0, 0,       0, I0, 0,       1);
        vecs[15] = v(0, 0,      1, 0, 0,            0, 1, 32'h200, 0, I0, 0,       1);
        vecs[16] = v(0, 0,      1, 1, I1,           0, 0, 0,       0, I0, 0,       1);
        vecs[17] = v(1, 32'h300,1, 0, 0,            0, 0, 0,       1, I1, 32'h200, 1);
        vecs[18] = v(0, 0,      1, 0, 0,            0, 1, 32'h300, 0, I1, 32'h200, 1);
        vecs[19] = v(0, 0,      1, 1, I2,           0, 0, 0,       0, I1, 32'h200, 1);
        vecs[20] = v(1, 32'h404,1, 0, 0,            1, 0, 0,       1, I2, 32'h300, 1);
        vecs[21] = v(1, 32'h500,1, 0, 0,            0, 0, 0,       0, I2, 32'h300, 2);
        vecs[22] = v(0, 0,      0, 0, 0,            0, 1, 32'h500, 0, I2, 32'h300, 2);
        vecs[23] = v(0, 0,      1, 0, 0,            0, 1, 32'h500, 0, I2, 32'h300, 2);
        vecs[24] = v(0, 0,      1, 0, 0,            0, 0, 0,       0, I2, 32'h300, 2);

        reset_main();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            imem_req_ready = vecs[i].rr;
            imem_rsp_valid = vecs[i].rsp;
            imem_rsp_data  = vecs[i].rdata;
            out_ready      = vecs[i].ordy;
            #1;
            chk($sformatf("row%0d_req_valid", i), imem_req_valid, vecs[i].e_rv);
            if (vecs[i].e_rv)
                chk($sformatf("row%0d_req_addr", i), imem_req_addr, vecs[i].e_ra);
            chk($sformatf("row%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("row%0d_out_instr", i), out_instr, vecs[i].e_instr);
            tmp = vecs[i].e_instr;
            chk($sformatf("row%0d_opcode", i), out_opcode, tmp[31:26]);
            chk($sformatf("row%0d_out_pc", i), out_pc, vecs[i].e_pc);
            chk($sformatf("row%0d_count", i), fetch_count, vecs[i].e_cnt);
            $display("row %0d: req_valid=%0b addr=%0h out_valid=%0b pc=%0h count=%0d",
                     i, imem_req_valid, imem_req_addr, out_valid, out_pc, fetch_count);
        end

        // ---------------- randomized run against reference model ----------------
        reset_main();
        m_pc = 32'h0; m_instr = 32'h0; m_outpc = 32'h0; m_cnt = 32'h0;
        m_hold = 1'b0; m_inflight = 1'b0; m_stale = 1'b0;
        mem_timer = 0; mem_data = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            imem_req_ready = 1'($urandom_range(0, 1));
            out_ready      = ($urandom_range(0, 2) != 0);
            imem_rsp_valid = (mem_timer == 1);
            imem_rsp_data  = imem_rsp_valid ? mem_data : $urandom;
            #1;
            exp_req = !m_hold && !m_inflight && !redirect_valid;
            chk("rnd_req_valid", imem_req_valid, exp_req);
            if (exp_req) chk("rnd_req_addr", imem_req_addr, m_pc);
            chk("rnd_out_valid", out_valid, m_hold);
            chk("rnd_out_instr", out_instr, m_instr);
            chk("rnd_opcode", out_opcode, m_instr[31:26]);
            chk("rnd_out_pc", out_pc, m_outpc);
            chk("rnd_count", fetch_count, m_cnt);
            if (c % 250 == 0)
                $display("rnd cycle %0d: out_valid=%0b pc=%0h count=%0d",
                         c, out_valid, out_pc, fetch_count);

            // memory: one response per accepted request, 1..3 cycles later
            accepted = exp_req && imem_req_ready;
            if (mem_timer > 0) mem_timer--;
            if (accepted) begin
                mem_timer = $urandom_range(1, 3);
                mem_data  = mem_word(m_pc);
            end

            // fetch model
            if (redirect_valid) begin
                if (m_hold) begin
                    if (out_ready) m_cnt = m_cnt + 1;
                    m_hold = 1'b0;
                end
                if (m_inflight) begin
                    if (imem_rsp_valid) begin
                        m_inflight = 1'b0;
                        m_stale    = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (accepted) begin
                m_inflight = 1'b1;
            end else if (m_inflight && imem_rsp_valid) begin
                m_inflight = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    m_hold   = 1'b1;
                    m_instr  = imem_rsp_data;
                    m_outpc  = m_pc;
                    m_pc     = m_pc + 4;
                end
            end else if (m_hold && out_ready) begin
                m_hold = 1'b0;
                m_cnt  = m_cnt + 1;
            end
        end

        // ---------------- pc wrap and reset mid-transaction (8-bit instance) ----------------
        @(negedge clk);
        #1;
        chk("w8_rst_req_valid", req_valid8, 1'b0);
        rst8 = 1'b0;
        @(negedge clk);
        req_ready8 = 1'b1;
        #1;
        chk("w8_req_valid", req_valid8, 1'b1);
        chk("w8_req_addr", req_addr8, 8'hFC);
        chk("w8_out_valid0", out_valid8, 1'b0);
        chk("w8_opcode0", out_opcode8, 6'h0);
        $display("w8: fetch at %0h", req_addr8);
        @(negedge clk);
        req_ready8 = 1'b0; rsp_valid8 = 1'b1; rsp_data8 = 32'h1000_0000;
        @(negedge clk);
        rsp_valid8 = 1'b0; out_ready8 = 1'b1;
        #1;
        chk("w8_out_valid", out_valid8, 1'b1);
        chk("w8_out_pc", out_pc8, 8'hFC);
        chk("w8_opcode", out_opcode8, 6'h04);
        $display("w8: out_pc=%0h opcode=%0h", out_pc8, out_opcode8);
        @(negedge clk);
        out_ready8 = 1'b0; req_ready8 = 1'b1;
        #1;
        chk("w8_wrap_req_valid", req_valid8, 1'b1);
        chk("w8_wrap_addr", req_addr8, 8'h00);
        chk("w8_count", fetch_count8, 8'd1);
        $display("w8: wrapped fetch at %0h count=%0d", req_addr8, fetch_count8);
        @(negedge clk);                 // now in WAIT
        req_ready8 = 1'b0; rst8 = 1'b1;
        @(negedge clk);
        #1;
        chk("w8_rstwait_req_valid", req_valid8, 1'b0);
        chk("w8_rstwait_out_valid", out_valid8, 1'b0);
        chk("w8_rstwait_pc", req_addr8, 8'hFC);
        chk("w8_rstwait_count", fetch_count8, 8'd0);
        $display("w8: reset in WAIT, addr=%0h req_valid=%0b", req_addr8, req_valid8);
        rst8 = 1'b0;
        @(negedge clk);
        req_ready8 = 1'b1;
        #1;
        chk("w8_after_rst_req", req_valid8, 1'b1);
        chk("w8_after_rst_addr", req_addr8, 8'hFC);
        @(negedge clk);
        req_ready8 = 1'b0; rsp_valid8 = 1'b1; rsp_data8 = 32'hFC00_0001;
        @(negedge clk);
        rsp_valid8 = 1'b0; rst8 = 1'b1;
        #1;
        chk("w8_full_out_valid", out_valid8, 1'b1);
        chk("w8_full_instr", out_instr8, 32'hFC00_0001);
        @(negedge clk);
        #1;
        chk("w8_rstfull_out_valid", out_valid8, 1'b0);
        chk("w8_rstfull_instr", out_instr8, 32'h0);
        chk("w8_rstfull_opcode", out_opcode8, 6'h0);
        $display("w8: reset in FULL, out_valid=%0b", out_valid8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
